// File: rtl/wb_arbiter_pipelined.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 slave among NM masters.
// A grant lasts a whole master bus cycle; a per-grant counter bounds outstanding requests.
module wb_arbiter_pipelined #(
  parameter int NM        = 2,
  parameter int adr_width = 16,
  parameter int dat_width = 16,
  parameter int MAX_OUT   = 4,
  localparam int OW       = $clog2(MAX_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NM-1:0]             m_cyc,
  input  logic [NM-1:0]             m_stb,
  input  logic [NM-1:0]             m_we,
  input  logic [NM*adr_width-1:0]   m_adr,
  input  logic [NM*dat_width-1:0]   m_dat_m,
  output logic [NM-1:0]             m_ack,
  output logic [NM-1:0]             m_stall,
  output logic [dat_width-1:0]      m_dat_s,
  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [adr_width-1:0]      s_adr,
  output logic [dat_width-1:0]      s_dat_m,
  input  logic                      s_ack,
  input  logic                      s_stall,
  input  logic [dat_width-1:0]      s_dat_s,
  output logic [NM-1:0]             gnt,
  output logic [OW-1:0]             outstd
);
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] gidx, gidx_nx, ptr, ptr_nx, sel;
  logic [NM-1:0] gnt_nx;
  logic [OW-1:0] outstd_nx;
  logic          found, own, full, accept;

  // First requester at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NM; i++) begin
      if (!found && m_cyc[(int'(ptr) + i) % NM]) begin
        found = 1'b1;
        sel   = IW'((int'(ptr) + i) % NM);
      end
    end
  end

  // Reset gates the bus combinationally so nothing leaks while rst is held low.
  assign own     = rst && (state == GRANT);
  assign full    = (outstd == OW'(MAX_OUT));
  assign s_cyc   = own && m_cyc[gidx];
  assign s_stb   = own && m_stb[gidx] && !full;
  assign s_we    = m_we[gidx];
  assign s_adr   = m_adr[int'(gidx)*adr_width +: adr_width];
  assign s_dat_m = m_dat_m[int'(gidx)*dat_width +: dat_width];
  assign m_dat_s = s_dat_s;
  assign accept  = s_stb && !s_stall;

  for (genvar i = 0; i < NM; i++) begin : g_m
    logic mine;
    assign mine       = own && (gidx == IW'(i));
    assign m_ack[i]   = mine && s_ack;
    assign m_stall[i] = !mine || s_stall || full;
  end

  always_comb begin
    state_nx  = state;
    gnt_nx    = gnt;
    gidx_nx   = gidx;
    ptr_nx    = ptr;
    outstd_nx = outstd;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx  = GRANT;
          gidx_nx   = sel;
          gnt_nx    = NM'(1) << sel;
          outstd_nx = '0;
        end
      end
      GRANT: begin
        if (!m_cyc[gidx]) begin
          // Release abandons any in-flight requests; rotate priority past the owner.
          state_nx  = IDLE;
          gnt_nx    = '0;
          outstd_nx = '0;
          ptr_nx    = (int'(gidx) == NM - 1) ? '0 : gidx + IW'(1);
        end else if (accept && !s_ack) begin
          outstd_nx = outstd + OW'(1);
        end else if (!accept && s_ack && (outstd != '0)) begin
          outstd_nx = outstd - OW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gidx   <= '0;
      ptr    <= '0;
      outstd <= '0;
    end else begin
      state  <= state_nx;
      gnt    <= gnt_nx;
      gidx   <= gidx_nx;
      ptr    <= ptr_nx;
      outstd <= outstd_nx;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_pipelined.sv
// Bench for wb_arbiter_pipelined: directed master traffic, a latency/stall slave model,
// and a per-cycle reference model of ownership, outstanding count and priority.
module tb_wb_arbiter_pipelined;
  localparam int NM = 2, AW = 16, DW = 16, MAX_OUT = 4, OW = $clog2(MAX_OUT + 1);

  logic              clk = 0, rst;
  logic [NM-1:0]     m_cyc, m_stb, m_we, m_ack, m_stall, gnt;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat_m;
  logic [DW-1:0]     m_dat_s, s_dat_m, s_dat_s;
  logic              s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [AW-1:0]     s_adr;
  logic [OW-1:0]     outstd;

  wb_arbiter_pipelined #(.NM(NM), .adr_width(AW), .dat_width(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_m(m_dat_m), .m_ack(m_ack), .m_stall(m_stall), .m_dat_s(m_dat_s),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m(s_dat_m),
    .s_ack(s_ack), .s_stall(s_stall), .s_dat_s(s_dat_s), .gnt(gnt), .outstd(outstd));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Slave: acks each accepted request dly cycles later, in order; optional periodic stall.
  int          dly = 1, cyc_n = 0;
  bit          stall_mode = 0;
  int          dueq[$];
  logic [31:0] slog[$];
  initial begin
    s_ack = 0; s_stall = 0; s_dat_s = '0;
    forever begin
      @(posedge clk); #1;
      cyc_n++;
      s_ack = 0;
      if (dueq.size() > 0 && dueq[0] <= cyc_n) begin
        s_ack = 1;
        void'(dueq.pop_front());
      end
      s_stall = stall_mode && (cyc_n % 4 == 3);
      s_dat_s = DW'(cyc_n * 7);
    end
  end
  always @(negedge clk) begin
    if (!rst) dueq.delete();
    else if (s_cyc && s_stb && !s_stall) begin
      dueq.push_back(cyc_n + dly);
      slog.push_back({s_adr, s_dat_m});
    end
  end

  // Reference model: owner (-1 = nobody), outstanding count, round-robin start index.
  int owner = -1, cnt = 0, rr = 0, n_owner = -1, n_cnt = 0, n_rr = 0;
  bit chk_en = 0, hold = 0, bad4 = 0, mon4 = 0;
  int peak = 0;
  int ackc[NM];

  always @(negedge clk) begin
    logic [NM-1:0] e_ack, e_stall, e_gnt;
    logic e_cyc, e_stb, acc, full;
    int g;
    if (chk_en) begin
      e_ack = '0; e_stall = '1; e_cyc = 0; e_stb = 0; full = 0; g = 0;
      e_gnt = (owner < 0) ? '0 : NM'(1) << owner;
      if (rst && owner >= 0) begin
        g = owner;
        full = (cnt == MAX_OUT);
        e_cyc = m_cyc[g];
        e_stb = m_stb[g] && !full;
        e_stall[g] = s_stall || full;
        e_ack[g] = s_ack;
      end
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("outstd", 32'(outstd), 32'(cnt));
      chk("s_cyc", 32'(s_cyc), 32'(e_cyc));
      chk("s_stb", 32'(s_stb), 32'(e_stb));
      chk("m_ack", 32'(m_ack), 32'(e_ack));
      chk("m_stall", 32'(m_stall), 32'(e_stall));
      chk("m_dat_s", 32'(m_dat_s), 32'(s_dat_s));
      if (e_cyc) begin
        chk("s_adr", 32'(s_adr), 32'(m_adr[g*AW +: AW]));
        chk("s_dat_m", 32'(s_dat_m), 32'(m_dat_m[g*DW +: DW]));
        chk("s_we", 32'(s_we), 32'(m_we[g]));
      end
      acc = e_stb && !s_stall;
      n_owner = owner; n_cnt = cnt; n_rr = rr;
      if (!rst) begin
        n_owner = -1; n_cnt = 0; n_rr = 0;
      end else if (owner < 0) begin
        for (int k = 0; k < NM; k++)
          if (n_owner < 0 && m_cyc[(rr + k) % NM]) n_owner = (rr + k) % NM;
        n_cnt = 0;
      end else if (!m_cyc[owner]) begin
        n_owner = -1; n_cnt = 0; n_rr = (owner + 1) % NM;
      end else if (!(acc && s_ack)) begin
        n_cnt = cnt + int'(acc) - int'(s_ack);
        if (n_cnt < 0) n_cnt = 0;
      end
      for (int m = 0; m < NM; m++) if (m_ack[m]) ackc[m]++;
      if (int'(outstd) > peak) peak = int'(outstd);
      if (outstd == OW'(MAX_OUT) && m_stb[0] && !s_stb && m_stall[0]) hold = 1;
      if (mon4 && (m_ack[1] || !m_stall[1])) bad4 = 1;
    end
  end
  always @(posedge clk) begin
    owner <= n_owner; cnt <= n_cnt; rr <= n_rr;
  end

  // Stall-aware pipelined write burst from master m.
  task automatic burst(input int m, input int n, input int adr0, input int dat0);
    int i = 0, guard = 0;
    logic st;
    m_cyc[m] = 1; m_we[m] = 1;
    while (i < n && guard < 300) begin
      m_stb[m] = 1;
      m_adr[m*AW +: AW] = AW'(adr0 + i);
      m_dat_m[m*DW +: DW] = DW'(dat0 + i);
      @(negedge clk); st = m_stall[m];
      @(posedge clk); #1;
      guard++;
      if (!st) i++;
    end
    m_stb[m] = 0;
    chk("burst_done", 32'(i), 32'(n));
  endtask

  task automatic wait_acks(input int m, input int n);
    int guard = 0;
    while (ackc[m] < n && guard < 200) begin
      @(posedge clk); guard++;
    end
    #1;
    chk("acks", 32'(ackc[m]), 32'(n));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_m = '0;
    for (int m = 0; m < NM; m++) ackc[m] = 0;
    repeat (2) tick();
    chk_en = 1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_outstd", 32'(outstd), 32'h0);
    chk("rst_scyc", 32'(s_cyc), 32'h0);
    chk("rst_stall", 32'(m_stall), 32'h3);
    rst = 1;

    // 10 pipelined writes from M0 against a periodically stalling slave.
    stall_mode = 1; slog.delete(); peak = 0;
    m_cyc[0] = 1;
    tick();
    chk("grant_latency", 32'(gnt), 32'h1);
    burst(0, 10, 11, 211);
    wait_acks(0, 10);
    chk("t1_end_outstd", 32'(outstd), 32'h0);
    chk("t1_count", 32'(slog.size()), 32'd10);
    for (int i = 0; i < 10 && i < slog.size(); i++)
      chk("t1_order", slog[i], {16'(11 + i), 16'(211 + i)});
    chk("t1_peak_ok", 32'(peak <= MAX_OUT), 32'h1);
    stall_mode = 0;
    m_cyc[0] = 0;
    tick();
    chk("t1_release", 32'(gnt), 32'h0);

    // Round-robin from a fresh reset.
    rst = 0; tick(); rst = 1;
    m_cyc = 2'b11; tick();
    chk("t2_tie", 32'(gnt), 32'h1);
    m_cyc[0] = 0; tick();
    chk("t2_gap_gnt", 32'(gnt), 32'h0);
    chk("t2_gap_scyc", 32'(s_cyc), 32'h0);
    tick();
    chk("t2_m1", 32'(gnt), 32'h2);
    m_cyc = 2'b00; tick();
    m_cyc = 2'b11; tick();
    chk("t2_rr", 32'(gnt), 32'h1);
    m_cyc = 2'b00; tick();

    // Slow acks: the counter saturates at MAX_OUT and holds the 5th request.
    dly = 6; ackc[0] = 0; peak = 0; hold = 0;
    burst(0, 8, 100, 300);
    wait_acks(0, 8);
    chk("t3_peak", 32'(peak), 32'(MAX_OUT));
    chk("t3_hold", 32'(hold), 32'h1);
    chk("t3_end_outstd", 32'(outstd), 32'h0);
    m_cyc[0] = 0; tick();

    // M1 waits behind a 20-cycle M0 burst.
    dly = 1; ackc[0] = 0; bad4 = 0;
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 0; m_adr[0 +: AW] = 16'h0040;
    tick();
    m_cyc[1] = 1; mon4 = 1;
    repeat (20) @(posedge clk);
    #1;
    mon4 = 0; m_stb[0] = 0; m_cyc[0] = 0;
    tick();
    chk("t4_gap", 32'(gnt), 32'h0);
    tick();
    chk("t4_m1", 32'(gnt), 32'h2);
    chk("t4_m1_blocked", 32'(bad4), 32'h0);
    chk("t4_m0_acks", 32'(ackc[0] >= 15), 32'h1);
    m_cyc[1] = 0; tick();

    // Abort with three requests outstanding; late acks must not reach M0.
    dly = 6; ackc[0] = 0;
    burst(0, 3, 500, 600);
    chk("t5_outstd3", 32'(outstd), 32'h3);
    m_cyc[0] = 0; tick();
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_outstd0", 32'(outstd), 32'h0);
    repeat (10) tick();
    chk("t5_late_ack", 32'(ackc[0]), 32'h0);

    // One-cycle reset in the middle of an M1 burst; priority restarts at M0.
    dly = 2;
    m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_adr[AW +: AW] = 16'h0077;
    repeat (4) tick();
    chk("t6_pre_gnt", 32'(gnt), 32'h2);
    chk("t6_pre_busy", 32'(outstd != 0), 32'h1);
    rst = 0; tick();
    rst = 1; m_cyc[0] = 1; #1;
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_outstd", 32'(outstd), 32'h0);
    chk("t6_scyc", 32'(s_cyc), 32'h0);
    @(posedge clk); #1;
    chk("t6_restart", 32'(gnt), 32'h1);
    m_cyc = '0; m_stb = '0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
